// File: rtl/rarp_pkg.sv
// rarp_pkg: definitions shared by the RARP transmit and receive blocks.
//   rarp_state_t    - control state of the word serialiser (IDLE/SEND/GAP)
//   RARP_NUM_WORDS  - number of 32-bit words in one ARP/RARP header
//   OP_RARP_*       - RARP request/reply opcodes
//   HTYPE_ETH, PTYPE_IPV4, HLEN, PLEN - usual Ethernet/IPv4 header values
package rarp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } rarp_state_t;

    localparam int unsigned RARP_NUM_WORDS = 7;

    localparam logic [15:0] OP_RARP_REQ = 16'd3;
    localparam logic [15:0] OP_RARP_REP = 16'd4;

    localparam logic [15:0] HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  HLEN       = 8'd6;
    localparam logic [7:0]  PLEN       = 8'd4;

endpackage

// File: rtl/rarp_tx.sv
// rarp_tx: serialises one ARP/RARP header into seven 32-bit words on a
// valid/ready stream, in the same word order the RARP receiver unpacks.
//
// Parameter:
//   GAP_CYCLES       idle cycles after the last word before a new start (0..255)
// Build option:
//   RARP_TX_OPCHECK_EN  when defined, a start whose opcode is not a RARP
//                       request/reply is rejected and flagged on err
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               send request, honoured only while idle
//   hdr_type .. target_ip_addr   header fields, captured on an accepted start
//   tx_word/tx_valid/tx_ready/tx_last   output word stream
//   busy                high while sending or in the post-packet gap
//   done                one-cycle pulse after the last word is accepted
//   err                 one-cycle pulse when a start is rejected
module rarp_tx
    import rarp_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] hdr_type,
    input  logic [15:0] proto_type,
    input  logic [7:0]  hdw_length,
    input  logic [7:0]  pro_length,
    input  logic [15:0] operation,
    input  logic [47:0] send_hdr_addr,
    input  logic [31:0] send_ip_addr,
    input  logic [47:0] target_hdr_addr,
    input  logic [31:0] target_ip_addr,
    output logic [31:0] tx_word,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LAST_IDX = 3'(RARP_NUM_WORDS - 1);
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    rarp_state_t   r_state;
    logic [223:0]  r_hold;
    logic [2:0]    r_cnt;
    logic [7:0]    r_gap;
    logic [31:0]   r_word;
    logic          r_valid;
    logic          r_last;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [223:0]  w_fields;
    logic          w_accept;
    logic          w_op_ok;
    logic [2:0]    w_cnt_nxt;

    // Field concatenation in transmit order: word k occupies bits
    // [223-32k -: 32], so W0 is the top 32 bits.
    assign w_fields = {hdr_type, proto_type, hdw_length, pro_length, operation,
                       send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr};

    assign w_accept  = r_valid & tx_ready;
    assign w_cnt_nxt = r_cnt + 3'd1;

`ifdef RARP_TX_OPCHECK_EN
    assign w_op_ok = (operation == OP_RARP_REQ) || (operation == OP_RARP_REP);
`else
    assign w_op_ok = 1'b1;
`endif

    function automatic logic [31:0] word_sel(input logic [223:0] h, input logic [2:0] idx);
        logic [31:0] w;
        case (idx)
            3'd0:    w = h[223:192];
            3'd1:    w = h[191:160];
            3'd2:    w = h[159:128];
            3'd3:    w = h[127:96];
            3'd4:    w = h[95:64];
            3'd5:    w = h[63:32];
            3'd6:    w = h[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_op_ok) begin
                            // W0 comes straight from the inputs so it is valid
                            // the cycle after start, without waiting on r_hold.
                            r_hold  <= w_fields;
                            r_word  <= word_sel(w_fields, 3'd0);
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (r_cnt == LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                            r_gap   <= '0;
                            if (GAP_CYCLES > 0) begin
                                r_state <= GAP;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt  <= w_cnt_nxt;
                            r_word <= word_sel(r_hold, w_cnt_nxt);
                            r_last <= (w_cnt_nxt == LAST_IDX);
                        end
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_gap   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_word  = r_word;
    assign tx_valid = r_valid;
    assign tx_last  = r_last;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_rarp_tx.sv
// tb_rarp_tx: scoreboard bench for rarp_tx (GAP_CYCLES = 3). Stimulus pushes
// expected words, first-word cycles and err cycles into queues; a negedge
// monitor pops and compares them, and re-assembles each packet into fields.
module tb_rarp_tx;
    import rarp_pkg::*;

    localparam int TB_GAP = 3;

    typedef struct packed {
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] op;
        logic [47:0] sha;
        logic [31:0] sip;
        logic [47:0] tha;
        logic [31:0] tip;
    } fld_t;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } ew_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] hdr_type;
    logic [15:0] proto_type;
    logic [7:0]  hdw_length;
    logic [7:0]  pro_length;
    logic [15:0] operation;
    logic [47:0] send_hdr_addr;
    logic [31:0] send_ip_addr;
    logic [47:0] target_hdr_addr;
    logic [31:0] target_ip_addr;
    logic [31:0] tx_word;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        done;
    logic        err;

    rarp_tx #(.GAP_CYCLES(TB_GAP)) dut (
        .clk(clk), .rst(rst), .start(start),
        .hdr_type(hdr_type), .proto_type(proto_type),
        .hdw_length(hdw_length), .pro_length(pro_length),
        .operation(operation),
        .send_hdr_addr(send_hdr_addr), .send_ip_addr(send_ip_addr),
        .target_hdr_addr(target_hdr_addr), .target_ip_addr(target_ip_addr),
        .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    ew_t  word_q[$];
    fld_t pkt_q[$];
    int   first_q[$];
    int   err_q[$];

    bit   mon_en = 1'b0;
    bit   pkt_pending = 1'b0;
    int   idle_at = 0;
    int   exp_done = -1;
    int   acc_idx = 0;
    logic prev_valid = 1'b0;
    logic [6:0][31:0] rx_words;

    int rdy_mode = 0;
    int stall_left = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, expv);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s at cycle %0d: bound expired", nm, cyc);
    endtask

    // Reference packing, written directly from the word layout table.
    function automatic logic [31:0] exp_word(input fld_t f, input int k);
        case (k)
            0:       return {f.htype, f.ptype};
            1:       return {f.hlen, f.plen, f.op};
            2:       return f.sha[47:16];
            3:       return {f.sha[15:0], f.sip[31:16]};
            4:       return {f.sip[15:0], f.tha[47:32]};
            5:       return f.tha[31:0];
            default: return f.tip;
        endcase
    endfunction

    // Receiver-side view: rebuild the header fields from seven words.
    function automatic fld_t unpack(input logic [6:0][31:0] w);
        fld_t f;
        f.htype = w[0][31:16];
        f.ptype = w[0][15:0];
        f.hlen  = w[1][31:24];
        f.plen  = w[1][23:16];
        f.op    = w[1][15:0];
        f.sha   = {w[2], w[3][31:16]};
        f.sip   = {w[3][15:0], w[4][31:16]};
        f.tha   = {w[4][15:0], w[5]};
        f.tip   = w[6];
        return f;
    endfunction

    function automatic bit op_ok(input logic [15:0] op);
`ifdef RARP_TX_OPCHECK_EN
        return (op == 16'd3) || (op == 16'd4);
`else
        return (op == op);
`endif
    endfunction

    function automatic fld_t rand_fields();
        fld_t f;
        f.htype = 16'($urandom);
        f.ptype = 16'($urandom);
        f.hlen  = 8'($urandom);
        f.plen  = 8'($urandom);
        case ($urandom_range(0, 5))
            0:       f.op = 16'($urandom);
            1, 2:    f.op = OP_RARP_REQ;
            default: f.op = OP_RARP_REP;
        endcase
        f.sha = {16'($urandom), 32'($urandom)};
        f.sip = 32'($urandom);
        f.tha = {16'($urandom), 32'($urandom)};
        f.tip = 32'($urandom);
        return f;
    endfunction

    task automatic drive_fields(input fld_t f);
        hdr_type        = f.htype;
        proto_type      = f.ptype;
        hdw_length      = f.hlen;
        pro_length      = f.plen;
        operation       = f.op;
        send_hdr_addr   = f.sha;
        send_ip_addr    = f.sip;
        target_hdr_addr = f.tha;
        target_ip_addr  = f.tip;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits until the model says the block is idle, then presents f with
    // start for one cycle (or leaves start high when keep is set). With
    // spam set, start and the field inputs are randomised while waiting.
    task automatic issue(input fld_t f, input bit keep, input bit spam);
        int guard = 0;
        while (pkt_pending || cyc < idle_at) begin
            if (spam) begin
                start = 1'($urandom_range(0, 1));
                drive_fields(rand_fields());
            end
            tick();
            guard++;
            if (guard > 3000) begin
                fail_now("issue_wait");
                return;
            end
        end
        drive_fields(f);
        start = 1'b1;
        if (op_ok(f.op)) begin
            for (int k = 0; k < 7; k++) word_q.push_back('{w: exp_word(f, k), last: (k == 6)});
            pkt_q.push_back(f);
            first_q.push_back(cyc + 1);
            pkt_pending = 1'b1;
        end else begin
            err_q.push_back(cyc + 1);
        end
        tick();
        if (!keep) start = 1'b0;
    endtask

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (acc_idx == 3 && stall_left > 0) begin
                        tx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            ew_t e;
            if (done || cyc == exp_done) begin
                chk("done_cycle", done ? cyc : -1, exp_done);
                exp_done = -1;
            end
            if (err || (err_q.size() > 0 && err_q[0] == cyc)) begin
                chk("err_cycle", err ? cyc : -1, (err_q.size() > 0) ? err_q[0] : -1);
                if (err_q.size() > 0) void'(err_q.pop_front());
            end
            if (tx_valid && !prev_valid) begin
                chk("first_word_cycle", cyc, (first_q.size() > 0) ? first_q[0] : -1);
                if (first_q.size() > 0) void'(first_q.pop_front());
            end
            prev_valid = tx_valid;
            if (!pkt_pending && first_q.size() == 0) begin
                if (cyc >= idle_at) chk("idle_valid_busy", {tx_valid, busy}, 2'b00);
                else                chk("gap_valid_busy", {tx_valid, busy}, 2'b01);
            end
            if (tx_valid) begin
                if (word_q.size() == 0) begin
                    chk("unexpected_word", tx_word, '0);
                    if (tx_word == '0) begin
                        miscompares++;
                        $display("FAIL unexpected_word at cycle %0d: tx_valid high with nothing queued", cyc);
                    end
                end else begin
                    e = word_q[0];
                    chk($sformatf("word%0d", acc_idx), {tx_word, tx_last, busy}, {e.w, e.last, 1'b1});
                    if (tx_ready) begin
                        if (acc_idx < 7) rx_words[acc_idx] = tx_word;
                        void'(word_q.pop_front());
                        acc_idx++;
                        if (e.last) begin
                            chk("loopback_fields", unpack(rx_words), (pkt_q.size() > 0) ? pkt_q[0] : '0);
                            if (pkt_q.size() > 0) void'(pkt_q.pop_front());
                            acc_idx     = 0;
                            pkt_pending = 1'b0;
                            exp_done    = cyc + 1;
                            idle_at     = cyc + 1 + TB_GAP;
                        end
                    end
                end
            end
        end
    end

    fld_t basic;
    fld_t f;
    int   guard;

    initial begin
        basic = '{htype: HTYPE_ETH, ptype: PTYPE_IPV4, hlen: HLEN, plen: PLEN,
                  op: OP_RARP_REQ, sha: 48'hAABBCCDDEEFF, sip: 32'hC0A80001,
                  tha: 48'h112233445566, tip: 32'hC0A80002};
        rst = 1'b1;
        start = 1'b0;
        drive_fields('0);
        repeat (3) tick();
        chk("reset_outputs", {tx_word, tx_valid, tx_last, busy, done, err}, '0);
        rst = 1'b0;
        idle_at = cyc;
        mon_en = 1'b1;
        tick();

        // Basic packet, ready always high.
        rdy_mode = 0;
        issue(basic, 1'b0, 1'b0);

        // Backpressure: three stall cycles on W3.
        stall_left = 3;
        rdy_mode = 2;
        issue(basic, 1'b0, 1'b0);
        issue(rand_fields(), 1'b0, 1'b0);
        rdy_mode = 0;

        // Start pulses and field changes while a packet is in flight.
        rdy_mode = 1;
        f = basic;
        f.op = OP_RARP_REP;
        issue(f, 1'b0, 1'b0);
        issue(basic, 1'b0, 1'b1);

        // Start held high across a packet and its gap.
        rdy_mode = 0;
        issue(basic, 1'b1, 1'b0);
        f = basic;
        f.tip = 32'hC0A800FE;
        issue(f, 1'b0, 1'b0);

        // Reset while W2 is on the bus.
        issue(basic, 1'b0, 1'b0);
        guard = 0;
        while (acc_idx != 2 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) fail_now("reach_w2");
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_reset_outputs", {tx_word, tx_valid, tx_last, busy, done, err}, '0);
        rst = 1'b0;
        word_q.delete();
        pkt_q.delete();
        first_q.delete();
        pkt_pending = 1'b0;
        exp_done = -1;
        acc_idx = 0;
        prev_valid = 1'b0;
        idle_at = cyc;
        mon_en = 1'b1;
        repeat (3) tick();
        issue(basic, 1'b0, 1'b0);

        // Opcode outside the RARP pair.
        f = basic;
        f.op = 16'h0001;
        issue(f, 1'b0, 1'b0);
        repeat (2) tick();

        // Randomised traffic.
        for (int n = 0; n < 30; n++) begin
            bit keep;
            bit spam;
            rdy_mode = int'($urandom_range(0, 1));
            f = rand_fields();
            keep = op_ok(f.op) && ($urandom_range(0, 3) == 0);
            spam = ($urandom_range(0, 2) == 0);
            if (start == 1'b0) begin
                repeat ($urandom_range(0, 2)) tick();
            end
            issue(f, keep, spam);
        end
        start = 1'b0;

        guard = 0;
        while ((pkt_pending || exp_done != -1 || err_q.size() > 0 || cyc < idle_at) && guard < 3000) begin
            tick();
            guard++;
        end
        if (guard >= 3000) fail_now("drain");
        repeat (4) tick();
        chk("queues_empty", word_q.size() + first_q.size() + err_q.size() + pkt_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
